// File: rtl/conv_pkg.sv
// Shared constants for the conv pixel/kernel streamer.
// CONV_STREAM_PACK_EN selects three pixels per PIXEL write.
package conv_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PIXEL  = 2'd1;
  localparam logic [1:0] REG_KERNEL = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_START   = 0;
  localparam int CTRL_ABORT   = 1;
  localparam int CTRL_KRELOAD = 2;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_STREAM = 2'd1;
  localparam state_t ST_DONE   = 2'd2;

  localparam int STS_LEVEL   = 0;
  localparam int STS_LEVEL_W = 5;
  localparam int STS_BUSY    = 5;
  localparam int STS_KLOAD   = 6;
  localparam int STS_KOVR    = 7;
  localparam int STS_DONE    = 8;
  localparam int STS_CNT     = 16;
  localparam int STS_CNT_W   = 16;

`ifdef CONV_STREAM_PACK_EN
  localparam int PACK_N = 3;
`else
  localparam int PACK_N = 1;
`endif

endpackage

// File: rtl/conv_pixel_fifo.sv
// Pixel FIFO with a PACK_N-wide write port and single pop.
// Width of the write port follows CONV_STREAM_PACK_EN via conv_pkg.
module conv_pixel_fifo
  import conv_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = 9,
  parameter int NP    = PACK_N,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          push,
  input  logic [NP*W-1:0] din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [LW-1:0] level,
  output logic [LW-1:0] free,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Caller guarantees room for NP entries and pop only when non-empty.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < NP; i++) begin
        mem[wr_ptr + AW'(i)] <= din[i*W +: W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(NP);
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level
             + (push ? LW'(NP) : '0)
             - (pop ? LW'(1) : '0);
    end
  end

  assign dout  = mem[rd_ptr];
  assign free  = LW'(DEPTH) - level;
  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/conv_pixel_streamer.sv
// Wishbone-fed pixel/kernel stream source for the convolver.
// CONV_STREAM_PACK_EN: PIXEL writes carry three pixels.
module conv_pixel_streamer
  import conv_pkg::*;
#(
  parameter int BITS        = 9,
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_LENGTH  = 128,
  parameter int IMG_HEIGHT  = 128,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            wbs_stb_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_adr_i,
  input  logic [31:0]     wbs_dat_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  output logic            img_write_en,
  output logic [BITS-1:0] img_input,
  output logic            kernel_write_en,
  output logic [BITS-1:0] kernel_in,
  output logic            frame_done
);

  localparam int KK    = KERNEL_SIZE * KERNEL_SIZE;
  localparam int FRAME = IMG_LENGTH * IMG_HEIGHT;
  localparam int CW    = $clog2(FRAME + 1);
  localparam int KW    = $clog2(KK + 1);
  localparam int LW    = $clog2(FIFO_DEPTH + 1);
  localparam int PW    = PACK_N * BITS;

  state_t          state;
  logic [CW-1:0]   pix_cnt;
  logic [KW-1:0]   k_cnt;
  logic            k_ovr;
  logic            k_pend;
  logic [BITS-1:0] k_data;
  logic            done_sticky;

  logic [1:0]      reg_sel;
  logic            req;
  logic            wr_take;
  logic            ctrl_w;
  logic            pix_w;
  logic            kern_w;
  logic            kern_ok;
  logic            stat_r;
  logic            abort;
  logic            start;
  logic            reload;
  logic            pop;
  logic            push;
  logic            room;
  logic            accept;
  logic            last;
  logic            k_loaded;
  logic [31:0]     status;

  logic [BITS-1:0] f_dout;
  logic [LW-1:0]   f_level;
  logic [LW-1:0]   f_free;
  logic            f_full;
  logic            f_empty;
  logic [LW:0]     avail;
  logic            unused;

  assign reg_sel = wbs_adr_i[3:2];
  assign req     = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign wr_take = req & wbs_we_i & wbs_sel_i[0];
  assign ctrl_w  = wr_take & (reg_sel == REG_CTRL);
  assign pix_w   = wr_take & (reg_sel == REG_PIXEL);
  assign kern_w  = wr_take & (reg_sel == REG_KERNEL);
  assign stat_r  = req & ~wbs_we_i & (reg_sel == REG_STATUS);

  assign abort  = ctrl_w & wbs_dat_i[CTRL_ABORT];
  assign start  = ctrl_w & wbs_dat_i[CTRL_START]
                & ~abort & (state == ST_IDLE);
  assign reload = start & wbs_dat_i[CTRL_KRELOAD];

  assign k_loaded = (k_cnt == KW'(KK));
  assign kern_ok  = kern_w & ~k_loaded;

  assign pop  = (state == ST_STREAM) & ~f_empty & ~abort;
  assign last = pop & (pix_cnt == CW'(FRAME - 1));

  // A pop in the same cycle frees a slot for a waiting PIXEL write.
  assign avail  = {1'b0, f_free} + {{LW{1'b0}}, pop};
  assign room   = (~f_full | pop) & (avail >= (LW+1)'(PACK_N));
  assign push   = pix_w & room;
  assign accept = req & (~pix_w | room);

  assign unused = ^{wbs_adr_i[31:4], wbs_adr_i[1:0],
                    wbs_sel_i[3:1], wbs_dat_i[31:PW]};

  conv_pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (BITS),
    .NP    (PACK_N)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (abort),
    .push    (push),
    .din     (wbs_dat_i[PW-1:0]),
    .pop     (pop),
    .dout    (f_dout),
    .level   (f_level),
    .free    (f_free),
    .full    (f_full),
    .empty   (f_empty)
  );

  always_comb begin
    status = '0;
    status[STS_LEVEL +: STS_LEVEL_W] = STS_LEVEL_W'(f_level);
    status[STS_BUSY]  = (state == ST_STREAM);
    status[STS_KLOAD] = k_loaded;
    status[STS_KOVR]  = k_ovr;
    status[STS_DONE]  = done_sticky;
    status[STS_CNT +: STS_CNT_W] = STS_CNT_W'(pix_cnt);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      pix_cnt     <= '0;
      done_sticky <= 1'b0;
    end else if (abort) begin
      state <= ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_STREAM;
            pix_cnt     <= '0;
            done_sticky <= 1'b0;
          end
        end
        ST_STREAM: begin
          if (pop) pix_cnt <= pix_cnt + 1'b1;
          if (last) state <= ST_DONE;
        end
        ST_DONE: begin
          state       <= ST_IDLE;
          done_sticky <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k_cnt           <= '0;
      k_ovr           <= 1'b0;
      k_pend          <= 1'b0;
      k_data          <= '0;
      kernel_write_en <= 1'b0;
      kernel_in       <= '0;
    end else begin
      k_pend          <= kern_ok;
      kernel_write_en <= k_pend;
      kernel_in       <= k_pend ? k_data : '0;
      if (kern_ok) begin
        k_cnt  <= k_cnt + 1'b1;
        k_data <= wbs_dat_i[BITS-1:0];
      end
      if (kern_w && !kern_ok) k_ovr <= 1'b1;
      if (reload) begin
        k_cnt <= '0;
        k_ovr <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wbs_ack_o    <= 1'b0;
      wbs_dat_o    <= '0;
      img_write_en <= 1'b0;
      img_input    <= '0;
      frame_done   <= 1'b0;
    end else begin
      wbs_ack_o    <= accept;
      wbs_dat_o    <= stat_r ? status : '0;
      img_write_en <= pop;
      img_input    <= pop ? f_dout : '0;
      frame_done   <= (state == ST_DONE) & ~abort;
    end
  end

endmodule

// File: doc/conv_pixel_streamer.md
Name: conv_pixel_streamer

Overview:
- Wishbone-fed transmitter that produces the serial pixel and kernel streams consumed by the convolve datapath: `img_write_en`/`img_input` and `kernel_write_en`/`kernel_in`.
- Firmware writes kernel coefficients and pixels over Wishbone. The block buffers pixels in a FIFO, streams one pixel per cycle during a frame, counts pixels and reports frame completion.
- Sits between the Wishbone slave port of user_proj_conv and the convolve instance. It replaces the io_in-driven stimulus path.

Parameters:
- BITS, 9, pixel and coefficient width.
- KERNEL_SIZE, 3, kernel edge; coefficients per load = KERNEL_SIZE*KERNEL_SIZE.
- IMG_LENGTH, 128, pixels per row.
- IMG_HEIGHT, 128, rows per frame.
- FIFO_DEPTH, 16, pixel FIFO entries; power of 2, minimum 4.

Ports:
- clk  in  1  single clock for the whole block.
- reset_n  in  1  asynchronous, active-low reset.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects; a write is taken only if wbs_sel_i[0]=1.
- wbs_adr_i  in  32  address; only bits [3:2] are decoded.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  single-cycle acknowledge.
- wbs_dat_o  out  32  read data.
- img_write_en  out  1  pixel strobe to the convolver.
- img_input  out  BITS  pixel value.
- kernel_write_en  out  1  coefficient strobe.
- kernel_in  out  BITS  coefficient value.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is sent.

Behaviour:
- Reset (reset_n=0, asynchronous): every output is 0. FIFO empty, counters 0, state IDLE, sticky bits clear.
- Register map (wbs_adr_i[3:2]):
  - 0 CTRL (W): bit0 START, bit1 ABORT.
  - 1 PIXEL (W): push wbs_dat_i[BITS-1:0] into the FIFO.
  - 2 KERNEL (W): forward wbs_dat_i[BITS-1:0] as a coefficient.
  - 3 STATUS (R): [4:0] FIFO level, [5] busy (state==STREAM), [6] kernel_loaded, [7] kernel_overrun, [8] done_sticky, [31:16] pixel count.
- Writes to STATUS and reads of other addresses: acked; reads return 0.
- Handshake:
  - valid = cyc & stb.
  - wbs_ack_o asserts for exactly one cycle, no earlier than 1 cycle after valid; never on two consecutive cycles.
  - PIXEL write with the FIFO full: ack is withheld until an entry frees. The write is never dropped.
  - Read data is registered and valid in the ack cycle.
- KERNEL write:
  - Counts 0..K*K−1. Each accepted write drives kernel_write_en=1 with kernel_in=data for exactly one cycle, in the cycle after ack.
  - At count K*K, kernel_loaded=1. Further KERNEL writes are acked, produce no strobe, and set kernel_overrun (sticky).
  - START clears the kernel count, kernel_loaded and kernel_overrun only when issued from IDLE with bit2=1 (KRELOAD).
- State machine:
  - IDLE: START=1 → STREAM. Clears pixel count and done_sticky.
  - STREAM: each cycle the FIFO is non-empty, pop one entry and drive img_write_en=1 with img_input = head value, registered (1-cycle latency pop→output). The FIFO empty mid-frame inserts bubbles (img_write_en=0); the pixel count does not advance. When pixel count reaches IMG_LENGTH*IMG_HEIGHT → DONE.
  - DONE: one-cycle frame_done pulse, done_sticky=1 → IDLE. Leftover FIFO contents are retained for the next frame.
  - ABORT in any state: → IDLE next cycle. FIFO flushed, img_write_en=0 that cycle, pixel count frozen for readout, no frame_done.
- Simultaneous push and pop: both occur; level unchanged. Push into an empty FIFO can be popped no earlier than the next cycle.
- In IDLE, pixels accumulate in the FIFO and are never streamed.
- Pixel count width: clog2(IMG_LENGTH*IMG_HEIGHT+1). STATUS zero-extends or truncates to 16 bits.

Optional Feature:
- Macro: CONV_STREAM_PACK_EN.
- Defined:
  - A PIXEL write carries 3 pixels in wbs_dat_i[3*BITS-1:0], lowest field first.
  - All 3 are pushed in the same cycle.
  - Ack is withheld until free entries ≥ 3.
  - FIFO write port is 3 wide.
- Undefined: one pixel per write as above; bits above BITS are ignored.

Decomposition:
- Package conv_pkg:
  - register offsets (REG_CTRL=0, REG_PIXEL=1, REG_KERNEL=2, REG_STATUS=3);
  - CTRL bit indices;
  - state enum (ST_IDLE, ST_STREAM, ST_DONE);
  - STATUS field positions.
- One sub-module, conv_pixel_fifo: parameterised depth and width, with push, pop, level, full, empty, flush. It has a push-count input of 1 or 3 under CONV_STREAM_PACK_EN.

Test Plan:
- Reset mid-stream: assert reset_n=0 while in STREAM with 5 entries queued → all outputs 0 at once; after release, STATUS reads 0.
- Kernel load:
  - 9 KERNEL writes of values 1..9 → 9 single-cycle kernel_write_en pulses, kernel_in=1..9 in order, STATUS[6]=1.
  - 10th write → no pulse, STATUS[7]=1.
- Frame run with IMG_LENGTH=4, IMG_HEIGHT=2:
  - push 8 pixels 10..17, then START → img_write_en high 8 consecutive cycles with 10..17;
  - frame_done pulses once, 1 cycle after the last pixel;
  - STATUS[8]=1, count=8.
- Backpressure: in IDLE push 17 pixels with FIFO_DEPTH=16 → 17th ack stalls; START → ack issues once the first pop occurs; output order is preserved.
- Underflow bubble: START with 2 pixels queued (frame=8) → 2 strobes, then img_write_en=0 and state stays STREAM; later pushes resume streaming, no frame_done until 8 are sent.
- ABORT after 3 of 8 pixels → no frame_done, FIFO level 0, STATUS count=3, state IDLE.
